// File: rtl/reflet_input_debouncer.sv
// reflet_input_debouncer: synchronises and debounces raw pad inputs into clean levels for gpi
//   clk, reset (sync, active-high), enable (low freezes counters at 0 and holds clean_out),
//   raw_in[width] async pads, clean_out[width] debounced levels, changed one-cycle update strobe.
//   Define REFLET_DEBOUNCE_EDGE_EN to add per-bit rise/fall strobes aligned with changed.
module reflet_input_debouncer #(
  parameter int width = 16,
  parameter int sync_stages = 2,
  parameter int debounce_cycles = 1000,
  parameter logic [width-1:0] reset_value = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [width-1:0] raw_in,
  output logic [width-1:0] clean_out,
  output logic             changed
`ifdef REFLET_DEBOUNCE_EDGE_EN
  ,
  output logic [width-1:0] rise,
  output logic [width-1:0] fall
`endif
);
  localparam int cw = $clog2(debounce_cycles + 1);
  localparam logic [cw-1:0] last = cw'(debounce_cycles - 1);
  logic [width-1:0] sync [sync_stages];
  logic [cw-1:0] cnt [width];
  logic [cw-1:0] cnt_n [width];
  logic [width-1:0] s;
  logic [width-1:0] upd;
  assign s = sync[sync_stages-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < sync_stages; i++) sync[i] <= reset_value;
    end else begin
      sync[0] <= raw_in;
      for (int i = 1; i < sync_stages; i++) sync[i] <= sync[i-1];
    end
  end
  // A bit updates on the edge where it has disagreed for debounce_cycles enabled cycles;
  // agreement, disable or the update itself all restart the count at 0.
  always_comb begin
    upd = '0;
    for (int b = 0; b < width; b++) begin
      upd[b] = enable && (s[b] != clean_out[b]) && (cnt[b] == last);
      cnt_n[b] = (enable && (s[b] != clean_out[b]) && !upd[b]) ? cnt[b] + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      clean_out <= reset_value;
      for (int b = 0; b < width; b++) cnt[b] <= '0;
    end else begin
      clean_out <= clean_out ^ upd;
      for (int b = 0; b < width; b++) cnt[b] <= cnt_n[b];
    end
  end
`ifdef REFLET_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= upd & s;
      fall <= upd & ~s;
    end
  end
  assign changed = |{rise, fall};
`else
  always_ff @(posedge clk) begin
    if (reset) changed <= 1'b0;
    else changed <= |upd;
  end
`endif
endmodule
